// File: rtl/dm_req_ctrl_if.sv
// Request/response handshake bundle between a requester and dm_req_ctrl.
// The requester drives the request side and the response-ready strobe;
// the controller drives request-ready and the response payload.
interface dm_req_ctrl_if;
    logic        req_vld;
    logic        req_wr;
    logic [12:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_rdy;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_data, rsp_err
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
        output req_rdy, rsp_vld, rsp_data, rsp_err
    );
endinterface

// File: rtl/dm_req_ctrl.sv
// Data-memory request controller: in-order request queue, one issue per
// cycle onto registered dm_* strobes, read credits so that every issued
// read has room in a 2-entry response FIFO. Out-of-range entries never
// touch the memory; reads answer with an error response, writes pulse wr_err.
module dm_req_ctrl #(
    parameter int QDEPTH   = 4,
    parameter int DM_WORDS = 2048
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_req_ctrl_if.slave bus,
    output logic         wr_err,
    output logic [12:0]  dm_addr,
    output logic         dm_re,
    output logic         dm_we,
    output logic [15:0]  dm_wrt_data,
    input  logic [15:0]  dm_rd_data
);
    localparam int          PW     = $clog2(QDEPTH);
    localparam logic [PW:0] Q_FULL = (PW+1)'(QDEPTH);
    localparam logic [13:0] DM_LIM = 14'(DM_WORDS);

    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [15:0] wdata;
    } req_t;

    // request queue
    req_t          q_mem_q [QDEPTH];
    req_t          q_mem_d [QDEPTH];
    logic [PW-1:0] q_wp_q, q_wp_d, q_rp_q, q_rp_d;
    logic [PW:0]   q_cnt_q, q_cnt_d;
    // response FIFO, entry = {err, data}
    logic [16:0]   r_mem_q [2];
    logic [16:0]   r_mem_d [2];
    logic          r_wp_q, r_wp_d, r_rp_q, r_rp_d;
    logic [1:0]    r_cnt_q, r_cnt_d;
    // read issued last cycle, its response lands at this edge
    logic          rd_pend_q, rd_pend_d, rd_err_q, rd_err_d;
    // memory-side strobes
    logic          dm_re_q, dm_re_d, dm_we_q, dm_we_d, wr_err_q, wr_err_d;
    logic [12:0]   dm_addr_q, dm_addr_d;
    logic [15:0]   dm_wdata_q, dm_wdata_d;

    req_t          head_s;
    logic          head_oor_s, q_push_s, q_pop_s, r_pop_s, rsp_vld_s;
    logic [2:0]    rd_occ_s;

    // Handshakes and the issue decision; a read needs a free response slot,
    // counting the slot freed by a response popped at this same edge.
    always_comb begin
        head_s     = q_mem_q[q_rp_q];
        head_oor_s = ({1'b0, head_s.addr} >= DM_LIM);
        q_push_s   = bus.req_vld && (q_cnt_q != Q_FULL);
        rsp_vld_s  = (r_cnt_q != 2'd0);
        r_pop_s    = rsp_vld_s && bus.rsp_rdy;
        rd_occ_s   = {1'b0, r_cnt_q} + {2'b00, rd_pend_q} - {2'b00, r_pop_s};
        if (q_cnt_q == (PW+1)'(0)) begin
            q_pop_s = 1'b0;
        end else if (head_s.wr) begin
            q_pop_s = 1'b1;
        end else begin
            q_pop_s = (rd_occ_s < 3'd2);
        end
    end

    // Next-state for queue, response FIFO and memory strobes.
    always_comb begin
        q_mem_d    = q_mem_q;
        r_mem_d    = r_mem_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        if (q_push_s) begin
            q_mem_d[q_wp_q] = {bus.req_wr, bus.req_addr, bus.req_wdata};
        end else begin
            q_mem_d[q_wp_q] = q_mem_q[q_wp_q];
        end
        q_wp_d  = q_push_s ? (q_wp_q + PW'(1)) : q_wp_q;
        q_rp_d  = q_pop_s  ? (q_rp_q + PW'(1)) : q_rp_q;
        q_cnt_d = q_cnt_q + (PW+1)'(q_push_s) - (PW+1)'(q_pop_s);

        dm_re_d   = q_pop_s && !head_s.wr && !head_oor_s;
        dm_we_d   = q_pop_s &&  head_s.wr && !head_oor_s;
        rd_pend_d = q_pop_s && !head_s.wr;
        rd_err_d  = q_pop_s && !head_s.wr && head_oor_s;
        wr_err_d  = q_pop_s &&  head_s.wr && head_oor_s;
        if (q_pop_s && !head_oor_s) begin
            dm_addr_d  = head_s.addr;
            dm_wdata_d = head_s.wdata;
        end else begin
            dm_addr_d  = dm_addr_q;
            dm_wdata_d = dm_wdata_q;
        end

        if (rd_pend_q) begin
            r_mem_d[r_wp_q] = {rd_err_q, rd_err_q ? 16'h0000 : dm_rd_data};
        end else begin
            r_mem_d[r_wp_q] = r_mem_q[r_wp_q];
        end
        r_wp_d  = r_wp_q ^ rd_pend_q;
        r_rp_d  = r_rp_q ^ r_pop_s;
        r_cnt_d = r_cnt_q + {1'b0, rd_pend_q} - {1'b0, r_pop_s};
    end

    // State registers; reset drops every pending request and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) q_mem_q[i] <= '0;
            r_mem_q[0] <= 17'h0;
            r_mem_q[1] <= 17'h0;
            q_wp_q     <= '0;
            q_rp_q     <= '0;
            q_cnt_q    <= '0;
            r_wp_q     <= 1'b0;
            r_rp_q     <= 1'b0;
            r_cnt_q    <= 2'd0;
            rd_pend_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            dm_re_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            wr_err_q   <= 1'b0;
            dm_addr_q  <= 13'h0;
            dm_wdata_q <= 16'h0;
        end else begin
            q_mem_q    <= q_mem_d;
            r_mem_q    <= r_mem_d;
            q_wp_q     <= q_wp_d;
            q_rp_q     <= q_rp_d;
            q_cnt_q    <= q_cnt_d;
            r_wp_q     <= r_wp_d;
            r_rp_q     <= r_rp_d;
            r_cnt_q    <= r_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_err_q   <= rd_err_d;
            dm_re_q    <= dm_re_d;
            dm_we_q    <= dm_we_d;
            wr_err_q   <= wr_err_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    assign bus.req_rdy  = (q_cnt_q != Q_FULL);
    assign bus.rsp_vld  = rsp_vld_s;
    assign bus.rsp_data = rsp_vld_s ? r_mem_q[r_rp_q][15:0] : 16'h0000;
    assign bus.rsp_err  = rsp_vld_s && r_mem_q[r_rp_q][16];
    assign wr_err       = wr_err_q;
    assign dm_re        = dm_re_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wrt_data  = dm_wdata_q;
endmodule

// File: tb/tb_dm_req_ctrl.sv
// Bench for dm_req_ctrl: negedge-updated memory model, shadow memory plus
// expected-response queue built from accepted requests, directed scenarios
// and a randomized phase.
module tb_dm_req_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_err, dm_re, dm_we;
    logic [12:0] dm_addr;
    logic [15:0] dm_wrt_data;
    logic [15:0] dm_rd_data = 16'h0;

    dm_req_ctrl_if bus_if ();

    dm_req_ctrl #(.QDEPTH(4), .DM_WORDS(2048)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if), .wr_err(wr_err),
        .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
        .dm_wrt_data(dm_wrt_data), .dm_rd_data(dm_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [15:0] dmem [2048];
    logic [15:0] ref_mem [2048];
    logic [16:0] exp_q [$];
    logic [16:0] e;
    int re_cnt = 0, we_cnt = 0, werr_cnt = 0, vld_cycles = 0;
    int exp_re = 0, exp_we = 0, exp_werr = 0;
    int cur_run = 0, max_run = 0;
    logic [12:0] last_we_addr = 13'h0;
    logic [15:0] last_we_data = 16'h0;
    logic        hold_v = 1'b0;
    logic [16:0] hold_val = 17'h0;
    int re0, we0, werr0, vld0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory model, reference model and protocol observations.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v  = 1'b0;
            cur_run = 0;
        end else begin
            chk("re_we_excl", 32'(dm_re && dm_we), 32'd0);
            if (dm_we) begin
                we_cnt++;
                last_we_addr = dm_addr;
                last_we_data = dm_wrt_data;
                dmem[dm_addr[10:0]] = dm_wrt_data;
            end
            if (dm_re) begin
                re_cnt++;
                dm_rd_data = dmem[dm_addr[10:0]];
            end
            if (wr_err) werr_cnt++;
            if (bus_if.rsp_vld) begin
                vld_cycles++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (hold_v)
                chk("rsp_hold", 32'({bus_if.rsp_vld, bus_if.rsp_err, bus_if.rsp_data}),
                    32'({1'b1, hold_val}));
            hold_v   = bus_if.rsp_vld && !bus_if.rsp_rdy;
            hold_val = {bus_if.rsp_err, bus_if.rsp_data};
            if (bus_if.rsp_vld && bus_if.rsp_rdy) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(bus_if.rsp_data), 32'(e[15:0]));
                    chk("rsp_err", 32'(bus_if.rsp_err), 32'(e[16]));
                end
            end
            if (bus_if.req_vld && bus_if.req_rdy) begin
                if (bus_if.req_addr >= 13'd2048) begin
                    if (bus_if.req_wr) exp_werr++;
                    else exp_q.push_back({1'b1, 16'h0000});
                end else if (bus_if.req_wr) begin
                    ref_mem[bus_if.req_addr[10:0]] = bus_if.req_wdata;
                    exp_we++;
                end else begin
                    exp_q.push_back({1'b0, ref_mem[bus_if.req_addr[10:0]]});
                    exp_re++;
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [12:0] addr, input logic [15:0] data);
        logic ok;
        ok = 1'b0;
        bus_if.req_vld   = 1'b1;
        bus_if.req_wr    = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = data;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = bus_if.req_rdy;
            @(posedge clk);
            #1;
        end
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus_if.req_vld = 1'b0;
        bus_if.rsp_rdy = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) cycles(1);
        cycles(8);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_rst();
        chk("rst_req_rdy", 32'(bus_if.req_rdy), 32'd1);
        chk("rst_rsp_vld", 32'(bus_if.rsp_vld), 32'd0);
        chk("rst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_dm_re", 32'(dm_re), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_dm_wdata", 32'(dm_wrt_data), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            dmem[i]    = 16'($urandom);
            ref_mem[i] = dmem[i];
        end
        rst_n = 1'b0;
        bus_if.req_vld = 1'b0; bus_if.req_wr = 1'b0;
        bus_if.req_addr = 13'h0; bus_if.req_wdata = 16'h0; bus_if.rsp_rdy = 1'b0;
        #2;
        chk_rst();
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        chk_rst();

        // write then read-after-write at 0x005
        bus_if.rsp_rdy = 1'b1;
        we0 = we_cnt;
        send(1'b1, 13'h005, 16'h1234);
        send(1'b0, 13'h005, 16'h0000);
        bus_if.req_vld = 1'b0;
        chk("raw_we", 32'(dm_we), 32'd1);
        chk("raw_we_addr", 32'(dm_addr), 32'h5);
        chk("raw_we_data", 32'(dm_wrt_data), 32'h1234);
        chk("raw_vld_e0", 32'(bus_if.rsp_vld), 32'd0);
        cycles(1);
        chk("raw_vld_e1", 32'(bus_if.rsp_vld), 32'd0);
        cycles(1);
        chk("raw_vld_e2", 32'(bus_if.rsp_vld), 32'd1);
        chk("raw_data", 32'(bus_if.rsp_data), 32'h1234);
        chk("raw_err", 32'(bus_if.rsp_err), 32'd0);
        drain();
        chk("raw_we_count", 32'(we_cnt - we0), 32'd1);
        chk("raw_last_addr", 32'(last_we_addr), 32'h5);

        // credit limit with a stalled consumer
        bus_if.rsp_rdy = 1'b0;
        re0 = re_cnt;
        for (int i = 0; i < 6; i++) send(1'b0, 13'($urandom_range(0, 2047)), 16'h0);
        bus_if.req_vld = 1'b0;
        chk("full_rdy", 32'(bus_if.req_rdy), 32'd0);
        cycles(5);
        chk("credit_re", 32'(re_cnt - re0), 32'd2);
        chk("full_rdy_hold", 32'(bus_if.req_rdy), 32'd0);
        drain();
        chk("credit_re_total", 32'(re_cnt - re0), 32'd6);

        // out-of-range read and write
        re0 = re_cnt; we0 = we_cnt; werr0 = werr_cnt;
        send(1'b0, 13'h0800, 16'h0);
        send(1'b1, 13'h1FFF, 16'hBEEF);
        bus_if.req_vld = 1'b0;
        cycles(1);
        chk("oor_rsp_vld", 32'(bus_if.rsp_vld), 32'd1);
        chk("oor_rsp_err", 32'(bus_if.rsp_err), 32'd1);
        chk("oor_rsp_data", 32'(bus_if.rsp_data), 32'd0);
        chk("oor_wr_err", 32'(wr_err), 32'd1);
        drain();
        chk("oor_no_re", 32'(re_cnt - re0), 32'd0);
        chk("oor_no_we", 32'(we_cnt - we0), 32'd0);
        chk("oor_werr_once", 32'(werr_cnt - werr0), 32'd1);

        // back-to-back reads sustain one response per cycle
        bus_if.rsp_rdy = 1'b1;
        max_run = 0;
        for (int i = 0; i < 8; i++) send(1'b0, 13'(i), 16'h0);
        bus_if.req_vld = 1'b0;
        drain();
        chk("b2b_run", 32'(max_run), 32'd8);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            int r;
            r = $urandom_range(0, 9);
            bus_if.req_vld   = ($urandom_range(0, 99) < 60);
            bus_if.req_wr    = 1'($urandom_range(0, 1));
            bus_if.req_addr  = (r == 0) ? 13'($urandom_range(2048, 8191)) :
                               (r < 5)  ? 13'($urandom_range(0, 7)) :
                                          13'($urandom_range(0, 2047));
            bus_if.req_wdata = 16'($urandom);
            bus_if.rsp_rdy   = ($urandom_range(0, 99) < 70);
            cycles(1);
        end
        drain();
        chk("total_we", 32'(we_cnt), 32'(exp_we));
        chk("total_re", 32'(re_cnt), 32'(exp_re));
        chk("total_werr", 32'(werr_cnt), 32'(exp_werr));

        // reset with three queued requests and one read in flight
        bus_if.rsp_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 13'($urandom_range(0, 2047)), 16'h0);
        bus_if.rsp_rdy = 1'b1;
        send(1'b0, 13'h0010, 16'h0);
        chk("inflight_pre", 32'(dm_re), 32'd1);
        rst_n = 1'b0;
        bus_if.req_vld = 1'b0;
        #1;
        chk_rst();
        exp_q.delete();
        re0 = re_cnt; we0 = we_cnt; vld0 = vld_cycles;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_dm", 32'(dm_re || dm_we), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(10);
        chk("post_rst_re", 32'(re_cnt - re0), 32'd0);
        chk("post_rst_we", 32'(we_cnt - we0), 32'd0);
        chk("post_rst_vld", 32'(vld_cycles - vld0), 32'd0);
        chk("post_rst_rdy", 32'(bus_if.req_rdy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
